// File: rtl/hex_display.sv
// rtl/hex_display.sv - multi-digit hex 7-segment driver with leading-zero blanking and blink
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   wr_en, wr_data      load the whole value (wins over dig_we)
//   dig_we, dig_sel,    replace one nibble; indices >= DIGITS are ignored
//   dig_data
//   blank_lz            blank leading zero digits (digit 0 always shown)
//   blink_en            blank every digit during the off half of the blink period
//   disp                registered active-low segments, bits 7k+6..7k = g..a of digit k
//   cur_value           stored value readback
module hex_display #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  dig_we,
  input  logic [2:0]            dig_sel,
  input  logic [3:0]            dig_data,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [7*DIGITS-1:0]   disp,
  output logic [4*DIGITS-1:0]   cur_value
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] val_q, val_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] disp_q, disp_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Value register: a full load overrides any single-digit write in the same cycle.
  // Looping only over existing digits makes out-of-range dig_sel a no-op.
  always_comb begin
    val_d = val_q;
    if (wr_en) begin
      val_d = wr_data;
    end else if (dig_we) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (dig_sel == 3'(k)) val_d[4*k +: 4] = dig_data;
      end
    end
  end

  // Free-running blink timebase; phase flips each time the counter wraps.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Walk from the most significant digit down, tracking whether every nibble
  // seen so far (including the current one) is zero.
  always_comb begin
    logic [3:0] nib;
    logic       zero_above;
    logic       lead_blank;
    disp_d     = '1;
    nib        = '0;
    zero_above = 1'b1;
    lead_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib        = val_q[4*k +: 4];
      zero_above = zero_above & (nib == 4'h0);
      lead_blank = blank_lz && (k > 0) && zero_above;
      if ((blink_en && !phase_q) || lead_blank) begin
        disp_d[7*k +: 7] = 7'h7F;
      end else begin
        disp_d[7*k +: 7] = seg7(nib);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      disp_q  <= '1;
    end else begin
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  assign disp      = disp_q;
  assign cur_value = val_q;

endmodule
